// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared constants for the pipelined control-word register.
//   DEFAULT_WIDTH : width of the stock 3-bit memory control word
//   DEFAULT_CW    : default width of the stall counter
//   WEN/REN/CSN   : bit positions of write-enable, read-enable and chip-select
//                   inside the control word
//   BUBBLE_WORD   : NOP encoding (no read, no write, chip deselected)
package pipe_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_CW    = 16;

    localparam int WEN = 0;
    localparam int REN = 1;
    localparam int CSN = 2;

    // All fields cleared: neither read nor write strobes, and the chip-select
    // field in its idle encoding, so a bubble can never touch memory.
    localparam logic [DEFAULT_WIDTH-1:0] BUBBLE_WORD = '0;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage
// One pipeline slot: a control word plus its valid bit.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset (slot becomes a bubble)
//   ENABLE     : 1 = load the upstream word, 0 = hold
//   FLUSH      : kill whatever would land in this slot this edge
//   LOAD_WORD  : upstream control word
//   LOAD_VALID : upstream valid bit
//   WORD       : registered control word
//   WORD_VALID : registered valid bit
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_WORD)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] LOAD_WORD,
    input  logic             LOAD_VALID,
    output logic [WIDTH-1:0] WORD,
    output logic             WORD_VALID
);

    // Reset beats flush, flush beats both shift and stall. An invalid word is
    // replaced by BUBBLE on load so an empty slot never carries stray control
    // bits, whatever the upstream data lines happen to hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WORD       <= BUBBLE;
            WORD_VALID <= 1'b0;
        end else if (FLUSH) begin
            WORD       <= BUBBLE;
            WORD_VALID <= 1'b0;
        end else if (ENABLE) begin
            WORD       <= LOAD_VALID ? LOAD_WORD : BUBBLE;
            WORD_VALID <= LOAD_VALID;
        end
    end

endmodule

// File: rtl/pipe_ctrl_reg.sv
// pipe_ctrl_reg
// STAGES-deep control-word pipeline with per-stage flush, stall hold,
// occupancy count and a saturating stall counter.
// Ports:
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   ENABLE     : 1 = advance every stage, 0 = stall
//   FLUSH_MASK : bit k turns stage k into a bubble this edge
//   CNT_CLR    : synchronous clear of STALL_CNT
//   D_IN       : control word entering stage 0
//   VALID_IN   : D_IN carries a real instruction
//   D_OUT      : control word of the last stage
//   VALID_OUT  : valid bit of the last stage
//   OCC        : number of valid stages
//   STALL_CNT  : saturating count of stalled cycles
module pipe_ctrl_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter int               STAGES = 1,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_WORD),
    parameter int               CW     = DEFAULT_CW
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ENABLE,
    input  logic [STAGES-1:0]            FLUSH_MASK,
    input  logic                         CNT_CLR,
    input  logic [WIDTH-1:0]             D_IN,
    input  logic                         VALID_IN,
    output logic [WIDTH-1:0]             D_OUT,
    output logic                         VALID_OUT,
    output logic [$clog2(STAGES+1)-1:0]  OCC,
    output logic [CW-1:0]                STALL_CNT
);

    localparam int            OW      = $clog2(STAGES + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]  stage_word [STAGES];
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] valid_next;
    logic [OW-1:0]     occ_next;

    // Each slot loads from its upstream neighbour; slot 0 loads the input.
    // The slot's next valid bit is mirrored here so OCC can be registered
    // on the same edge as the slots themselves instead of lagging a cycle.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] load_word;
        logic             load_valid;

        if (k == 0) begin : g_head
            assign load_word  = D_IN;
            assign load_valid = VALID_IN;
        end else begin : g_body
            assign load_word  = stage_word[k-1];
            assign load_valid = stage_valid[k-1];
        end

        assign valid_next[k] = RST           ? 1'b0 :
                               FLUSH_MASK[k] ? 1'b0 :
                               ENABLE        ? load_valid : stage_valid[k];

        pipe_ctrl_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .CLK        (CLK),
            .RST        (RST),
            .ENABLE     (ENABLE),
            .FLUSH      (FLUSH_MASK[k]),
            .LOAD_WORD  (load_word),
            .LOAD_VALID (load_valid),
            .WORD       (stage_word[k]),
            .WORD_VALID (stage_valid[k])
        );
    end

    assign D_OUT     = stage_word[STAGES-1];
    assign VALID_OUT = stage_valid[STAGES-1];

    // Population count of the post-edge valid bits.
    always_comb begin
        occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_next = occ_next + OW'(valid_next[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OCC <= '0;
        end else begin
            OCC <= occ_next;
        end
    end

    // Clear wins over increment; the count sticks at all-ones rather than
    // wrapping so a long stall is never mistaken for a short one.
    always_ff @(posedge CLK) begin
        if (RST || CNT_CLR) begin
            STALL_CNT <= '0;
        end else if (!ENABLE && STALL_CNT != CNT_MAX) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// tb_pipe_ctrl_reg
// Drives three pipe_ctrl_reg instances from one stimulus stream:
//   dut_a : STAGES=3, CW=16
//   dut_b : STAGES=3, CW=4  (stall-counter saturation)
//   dut_c : STAGES=1, CW=16 (single register case, flush bit 0 only)
// Expected values come from a slot-list model of the pipeline.
module tb_pipe_ctrl_reg;

    localparam logic [2:0] TB_BUBBLE = 3'b000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ENABLE;
    logic [2:0] FLUSH_MASK;
    logic       CNT_CLR;
    logic [2:0] D_IN;
    logic       VALID_IN;

    logic [2:0]  d_out_a, d_out_b, d_out_c;
    logic        valid_out_a, valid_out_b, valid_out_c;
    logic [1:0]  occ_a, occ_b;
    logic [0:0]  occ_c;
    logic [15:0] stall_a, stall_c;
    logic [3:0]  stall_b;

    int checks = 0;
    int errors = 0;

    // Reference model: slot 0 is the entry, slot 2 the exit.
    logic [2:0] m_word [3];
    bit         m_valid [3];
    logic [2:0] s_word;
    bit         s_valid;
    int         m_cnt16;
    int         m_cnt4;

    always #5 CLK = ~CLK;

    pipe_ctrl_reg #(.WIDTH(3), .STAGES(3), .CW(16)) dut_a (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FLUSH_MASK(FLUSH_MASK),
        .CNT_CLR(CNT_CLR), .D_IN(D_IN), .VALID_IN(VALID_IN),
        .D_OUT(d_out_a), .VALID_OUT(valid_out_a), .OCC(occ_a), .STALL_CNT(stall_a)
    );

    pipe_ctrl_reg #(.WIDTH(3), .STAGES(3), .CW(4)) dut_b (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FLUSH_MASK(FLUSH_MASK),
        .CNT_CLR(CNT_CLR), .D_IN(D_IN), .VALID_IN(VALID_IN),
        .D_OUT(d_out_b), .VALID_OUT(valid_out_b), .OCC(occ_b), .STALL_CNT(stall_b)
    );

    pipe_ctrl_reg #(.WIDTH(3), .STAGES(1), .CW(16)) dut_c (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FLUSH_MASK(FLUSH_MASK[0]),
        .CNT_CLR(CNT_CLR), .D_IN(D_IN), .VALID_IN(VALID_IN),
        .D_OUT(d_out_c), .VALID_OUT(valid_out_c), .OCC(occ_c), .STALL_CNT(stall_c)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic modelStep();
        logic [2:0] nw [3];
        bit         nv [3];
        logic [2:0] entry;
        entry = VALID_IN ? D_IN : TB_BUBBLE;
        if (RST) begin
            for (int k = 0; k < 3; k++) begin
                m_word[k]  = TB_BUBBLE;
                m_valid[k] = 0;
            end
            s_word  = TB_BUBBLE;
            s_valid = 0;
            m_cnt16 = 0;
            m_cnt4  = 0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            nw[k] = m_word[k];
            nv[k] = m_valid[k];
        end
        if (ENABLE) begin
            nw[0] = entry;
            nv[0] = VALID_IN;
            for (int k = 1; k < 3; k++) begin
                nw[k] = m_word[k-1];
                nv[k] = m_valid[k-1];
            end
            s_word  = entry;
            s_valid = VALID_IN;
        end
        for (int k = 0; k < 3; k++) begin
            if (FLUSH_MASK[k]) begin
                nw[k] = TB_BUBBLE;
                nv[k] = 0;
            end
            m_word[k]  = nw[k];
            m_valid[k] = nv[k];
        end
        if (FLUSH_MASK[0]) begin
            s_word  = TB_BUBBLE;
            s_valid = 0;
        end
        if (CNT_CLR) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else if (!ENABLE) begin
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
            m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
        end
    endtask

    task automatic checkAll();
        int occ;
        occ = 0;
        for (int k = 0; k < 3; k++) occ += m_valid[k];
        checkOutput("a_d_out",     32'(d_out_a),     32'(m_word[2]));
        checkOutput("a_valid_out", 32'(valid_out_a), 32'(m_valid[2]));
        checkOutput("a_occ",       32'(occ_a),       32'(occ));
        checkOutput("a_stall_cnt", 32'(stall_a),     32'(m_cnt16));
        checkOutput("b_d_out",     32'(d_out_b),     32'(m_word[2]));
        checkOutput("b_occ",       32'(occ_b),       32'(occ));
        checkOutput("b_stall_cnt", 32'(stall_b),     32'(m_cnt4));
        checkOutput("c_d_out",     32'(d_out_c),     32'(s_word));
        checkOutput("c_valid_out", 32'(valid_out_c), 32'(s_valid));
        checkOutput("c_occ",       32'(occ_c),       32'(s_valid));
        checkOutput("c_stall_cnt", 32'(stall_c),     32'(m_cnt16));
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit vin,
                                 input logic [2:0] din, input logic [2:0] mask,
                                 input bit clr);
        RST        = rst;
        ENABLE     = en;
        VALID_IN   = vin;
        D_IN       = din;
        FLUSH_MASK = mask;
        CNT_CLR    = clr;
        @(posedge CLK);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b0; VALID_IN = 1'b0; D_IN = 3'b000;
        FLUSH_MASK = 3'b000; CNT_CLR = 1'b0;

        // Two reset cycles, with other controls active to show reset wins.
        applyStimulus(1, 1, 1, 3'b111, 3'b000, 0);
        applyStimulus(1, 0, 1, 3'b101, 3'b000, 0);
        checkOutput("reset_d_out", 32'(d_out_a), 32'(TB_BUBBLE));
        checkOutput("reset_occ",   32'(occ_a),   32'd0);

        // Fill with three words; they leave in order.
        applyStimulus(0, 1, 1, 3'b101, 3'b000, 0);
        applyStimulus(0, 1, 1, 3'b011, 3'b000, 0);
        applyStimulus(0, 1, 1, 3'b110, 3'b000, 0);
        checkOutput("fill_head", 32'(d_out_a), 32'(3'b101));
        checkOutput("fill_occ",  32'(occ_a),   32'd3);

        // Five stall cycles, then clear during stall.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 3'b111, 3'b000, 0);
        checkOutput("stall_five", 32'(stall_a), 32'd5);
        applyStimulus(0, 0, 1, 3'b111, 3'b000, 1);
        checkOutput("stall_clr", 32'(stall_a), 32'd0);

        // Flush the middle stage while stalled.
        applyStimulus(0, 0, 0, 3'b000, 3'b010, 0);
        checkOutput("flush_mid_occ", 32'(occ_a), 32'd2);

        // Drain the bubble, refill, then reset mid-stream with everything on.
        applyStimulus(0, 1, 1, 3'b001, 3'b000, 0);
        applyStimulus(0, 1, 0, 3'b111, 3'b000, 0);
        applyStimulus(0, 1, 1, 3'b100, 3'b000, 0);
        applyStimulus(1, 1, 1, 3'b010, 3'b111, 0);
        applyStimulus(0, 1, 1, 3'b011, 3'b000, 0);
        applyStimulus(0, 1, 0, 3'b000, 3'b000, 0);
        applyStimulus(0, 0, 0, 3'b000, 3'b000, 0);
        applyStimulus(0, 1, 0, 3'b101, 3'b000, 0);
        checkOutput("post_reset_emerge", 32'(d_out_a), 32'(3'b011));

        // Long stall: 4-bit counter saturates at 15.
        applyStimulus(0, 1, 0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 3'b000, 3'b000, 0);
        checkOutput("sat_cw4", 32'(stall_b), 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                          $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
